sfm_minmax_corr_buffer: RTL
===========================

// Module: sfm_minmax_corr_buffer
// PURPOSE
//  Downstream companion of the global min/max tracker. Each time a beat raises the running
//  extreme (new_flg), the denominator accumulator must be rescaled by exp(old - new).
//  This block queues those correction events as (old, new, beat index) records for the accumulator.
//  When the queue is full, it coalesces events losslessly: exp(a-b)*exp(b-c) = exp(a-c).
// PARAMETERS
//  FPFORMAT   fpnew_pkg::FP16ALT  float format of min/max values
//  DEPTH      4                   correction queue entries (>=1)
//  CNT_WIDTH  16                  beat index counter width
//  WIDTH      localparam          fpnew_pkg::fp_width(FPFORMAT)
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  clear_i        in   1          synchronous flush (queue, counter)
//  beat_valid_i   in   1          min/max stage delivered a reduced beat this cycle (valid & ready)
//  new_flg_i      in   1          beat raised the running extreme
//  cur_minmax_i   in   WIDTH      extreme before this beat
//  new_minmax_i   in   WIDTH      extreme after this beat
//  corr_valid_o   out  1          head record available
//  corr_ready_i   in   1          accumulator accepts head record
//  corr_old_o     out  WIDTH      head: old extreme
//  corr_new_o     out  WIDTH      head: new extreme
//  corr_beat_o    out  CNT_WIDTH  head: beat index of the latest update folded into the record
//  corr_merged_o  out  1          head: record is a coalesced result of >=2 events
//  level_o        out  $clog2(DEPTH+1)  occupied entries
//  beat_cnt_o     out  CNT_WIDTH  beats seen since clear
// BEHAVIOUR
//  - Reset: queue empty, corr_valid_o=0, corr_old/new/beat=0, corr_merged_o=0, level_o=0, beat_cnt_o=0.
//  - Beat counter: +1 on every beat_valid_i; wraps from 2^CNT_WIDTH-1 to 0. A record is
//    tagged with the pre-increment value.
//  - push = beat_valid_i & new_flg_i; new_flg_i is ignored while beat_valid_i=0.
//  - pop = corr_valid_o & corr_ready_i; corr_valid_o = (level_o != 0).
//  - Queue is circular FWFT with registered storage. A push into an empty queue is visible next cycle.
//    There is no same-cycle bypass.
//  - Push with level<DEPTH, or with a same-cycle pop: append {cur,new,idx,merged=0}.
//  - Simultaneous push+pop: level is unchanged, including when full.
//  - Push with level==DEPTH and no pop: coalesce into the tail entry. tail.new<=new_minmax_i,
//    tail.beat<=idx, tail.merged<=1, and tail.old is kept. The queue never drops an event and
//    never back-pressures upstream.
//  - DEPTH=1, full, no pop: the head is coalesced and the outputs update next cycle.
//    corr_valid_o stays high.
//  - Pop without push: head advances, level-1. Pop while empty is impossible (corr_valid_o=0).
//  - clear_i has priority over push, pop and counting. Next cycle the block is in its reset state,
//    except record payload registers, which are don't-care.
//  - Values pass through bit-exact; no FP arithmetic is performed here. -inf/+inf old values
//    (first event after clear) are legal.
//  - Head outputs hold stable while corr_valid_o=1 & corr_ready_i=0, unless coalescing
//    targets the head (level==1==DEPTH case only).
// TESTING (FP16ALT: 1.0=3F80 2.0=4000 4.0=4080 8.0=4100 -inf=FF80)
//  1. After clear: beat 0 with flg, cur=FF80, new=3F80, ready=1.
//     -> next cycle valid=1, old=FF80, new=3F80, beat=0, merged=0. Pop leaves level 0.
//  2. DEPTH=4, ready=0, five flg beats with 1->2->4->8->16 (new=4180, idx 0..4).
//     -> level=4; the 4th entry is old=4080, new=4180, beat=4, merged=1.
//  3. Queue full, push and pop in the same cycle.
//     -> level stays 4, no merge; the popped head was old=FF80, new=3F80.
//  4. 10 beats, flg only on beats 3 and 7.
//     -> records carry beat=3 and beat=7; beat_cnt_o=10.
//  5. CNT_WIDTH=4, 17 beats, flg on the last one.
//     -> corr_beat_o=0 (wrapped); beat_cnt_o=1.
//  6. clear_i with level=3, same cycle as a flg push.
//     -> next cycle level=0, valid=0, beat_cnt_o=0. Assert rst_ni mid-stream -> same state immediately.

Source files
------------

// File: rtl/sfm_minmax_corr_buffer.sv
// Correction-event queue for the softmax denominator: records (old, new, beat) on each
// running-extreme update and coalesces into the tail when full so no event is ever lost.
module sfm_minmax_corr_buffer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 beat_valid_i,
    input  logic                 new_flg_i,
    input  logic [WIDTH-1:0]     cur_minmax_i,
    input  logic [WIDTH-1:0]     new_minmax_i,
    output logic                 corr_valid_o,
    input  logic                 corr_ready_i,
    output logic [WIDTH-1:0]     corr_old_o,
    output logic [WIDTH-1:0]     corr_new_o,
    output logic [CNT_WIDTH-1:0] corr_beat_o,
    output logic                 corr_merged_o,
    output logic [LVL_W-1:0]     level_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage is padded to a power of two so pointers index it without width games.
    localparam int unsigned SLOTS = 1 << PTR_W;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0]     r_old    [SLOTS];
    logic [WIDTH-1:0]     r_new    [SLOTS];
    logic [CNT_WIDTH-1:0] r_beat   [SLOTS];
    logic                 r_merged [SLOTS];

    ptr_t                 r_rd_ptr, w_rd_ptr_d;
    ptr_t                 r_wr_ptr, w_wr_ptr_d;
    logic [LVL_W-1:0]     r_level, w_level_d;
    logic [CNT_WIDTH-1:0] r_beat_cnt, w_beat_cnt_d;

    logic w_push, w_pop, w_full, w_append, w_coalesce;
    ptr_t w_tail;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

    assign w_push     = beat_valid_i & new_flg_i;
    assign w_pop      = corr_valid_o & corr_ready_i;
    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_append   = w_push & (~w_full | w_pop);
    assign w_coalesce = w_push & w_full & ~w_pop;
    assign w_tail     = (r_wr_ptr == '0) ? ptr_t'(DEPTH - 1) : ptr_t'(r_wr_ptr - ptr_t'(1));

    always_comb begin
        w_rd_ptr_d   = r_rd_ptr;
        w_wr_ptr_d   = r_wr_ptr;
        w_level_d    = r_level;
        w_beat_cnt_d = r_beat_cnt;
        if (clear_i) begin
            w_rd_ptr_d   = '0;
            w_wr_ptr_d   = '0;
            w_level_d    = '0;
            w_beat_cnt_d = '0;
        end else begin
            if (beat_valid_i) begin
                w_beat_cnt_d = r_beat_cnt + CNT_WIDTH'(1);
            end
            if (w_append) begin
                w_wr_ptr_d = ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                w_rd_ptr_d = ptr_inc(r_rd_ptr);
            end
            if (w_append && !w_pop) begin
                w_level_d = r_level + LVL_W'(1);
            end else if (w_pop && !w_append) begin
                w_level_d = r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_rd_ptr   <= w_rd_ptr_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_level    <= w_level_d;
            r_beat_cnt <= w_beat_cnt_d;
        end
    end

    // Coalescing keeps the tail's old value so exp(old-new) composes across merged events.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                r_old[i]    <= '0;
                r_new[i]    <= '0;
                r_beat[i]   <= '0;
                r_merged[i] <= 1'b0;
            end
        end else if (!clear_i) begin
            if (w_append) begin
                r_old[r_wr_ptr]    <= cur_minmax_i;
                r_new[r_wr_ptr]    <= new_minmax_i;
                r_beat[r_wr_ptr]   <= r_beat_cnt;
                r_merged[r_wr_ptr] <= 1'b0;
            end else if (w_coalesce) begin
                r_new[w_tail]    <= new_minmax_i;
                r_beat[w_tail]   <= r_beat_cnt;
                r_merged[w_tail] <= 1'b1;
            end
        end
    end

    assign corr_valid_o  = (r_level != '0);
    assign corr_old_o    = r_old[r_rd_ptr];
    assign corr_new_o    = r_new[r_rd_ptr];
    assign corr_beat_o   = r_beat[r_rd_ptr];
    assign corr_merged_o = r_merged[r_rd_ptr];
    assign level_o       = r_level;
    assign beat_cnt_o    = r_beat_cnt;

endmodule
